// File: rtl/fetch_pc_gen_pkg.sv
// +--------------------------------------------------------------+
// | fetch_pc_gen_pkg : shared widths and fetch FSM encodings     |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef IFU_ST_REQ
`define IFU_ST_REQ       2'd0
`define IFU_ST_RSP       2'd1
`define IFU_ST_JALR_WAIT 2'd2
`define IFU_ST_DROP      2'd3
`endif

package fetch_pc_gen_pkg;
  localparam int XLEN          = `XLEN;
  localparam int INSTR_WIDTH   = `INSTR_WIDTH;
  localparam int REG_IDX_WIDTH = `REG_IDX_WIDTH;

  typedef enum logic [1:0] {
    ST_REQ       = `IFU_ST_REQ,
    ST_RSP       = `IFU_ST_RSP,
    ST_JALR_WAIT = `IFU_ST_JALR_WAIT,
    ST_DROP      = `IFU_ST_DROP
  } ifu_state_e;
endpackage

`default_nettype wire

// File: rtl/fetch_next_pc.sv
// +--------------------------------------------------------------+
// | fetch_next_pc : static next-PC and taken-prediction select   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module fetch_next_pc
  import fetch_pc_gen_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            bxx_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            pred_taken_o
);
  logic use_imm;

  // Backward conditional branches are predicted taken.
  assign use_imm      = jal_i | (bxx_i & imm_i[XLEN-1]);
  assign pred_taken_o = use_imm | jalr_i;
  assign next_pc_o    = use_imm ? (pc_i + imm_i) : (pc_i + XLEN'(4));
endmodule

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
// +--------------------------------------------------------------+
// | fetch_pc_gen : fetch PC generator and instruction buffer     |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ifu_req_valid_o,
  input  logic                     ifu_req_ready_i,
  output logic [XLEN-1:0]          ifu_req_pc_o,
  input  logic                     ifu_rsp_valid_i,
  output logic                     ifu_rsp_ready_o,
  input  logic [INSTR_WIDTH-1:0]   ifu_rsp_instr_i,
  input  logic                     dec_bxx_i,
  input  logic                     dec_jal_i,
  input  logic                     dec_jalr_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_jalr_rs1_idx_i,
  input  logic [XLEN-1:0]          dec_bjp_imm_i,
  output logic [REG_IDX_WIDTH-1:0] rf_rs1_idx_o,
  input  logic [XLEN-1:0]          rf_rs1_data_i,
  input  logic                     rf_rs1_busy_i,
  input  logic                     flush_i,
  input  logic [XLEN-1:0]          flush_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [INSTR_WIDTH-1:0]   out_instr_o,
  output logic [XLEN-1:0]          out_pc_o,
  output logic                     out_pred_taken_o
);
  ifu_state_e               state_q, state_d;
  logic [XLEN-1:0]          pc_q, pc_d;
  logic                     out_valid_q, out_valid_d;
  logic [INSTR_WIDTH-1:0]   out_instr_q, out_instr_d;
  logic [XLEN-1:0]          out_pc_q, out_pc_d;
  logic                     out_pred_q, out_pred_d;
  logic [REG_IDX_WIDTH-1:0] jalr_rs1_idx_q, jalr_rs1_idx_d;
  logic [XLEN-1:0]          jalr_imm_q, jalr_imm_d;

  logic [XLEN-1:0] next_pc;
  logic            pred_taken;
  logic            rsp_fire;
  logic            rs1_ready;
  logic [XLEN-1:0] rs1_operand;
  logic [XLEN-1:0] jalr_sum;

  fetch_next_pc u_next_pc (
    .pc_i         (pc_q),
    .imm_i        (dec_bjp_imm_i),
    .bxx_i        (dec_bxx_i),
    .jal_i        (dec_jal_i),
    .jalr_i       (dec_jalr_i),
    .next_pc_o    (next_pc),
    .pred_taken_o (pred_taken)
  );

  // Withholding the request during a flush keeps an orphan response from being fetched.
  assign ifu_req_valid_o = ~rst_i & ~flush_i & (state_q == ST_REQ);
  assign ifu_req_pc_o    = pc_q;
  assign ifu_rsp_ready_o = ~rst_i &
                           (((state_q == ST_RSP) & (~out_valid_q | out_ready_i | flush_i)) |
                            (state_q == ST_DROP));
  assign rsp_fire        = ifu_rsp_valid_i & ifu_rsp_ready_o;

  assign rf_rs1_idx_o = jalr_rs1_idx_q;
  assign rs1_ready    = (jalr_rs1_idx_q == '0) | ~rf_rs1_busy_i;
  assign rs1_operand  = (jalr_rs1_idx_q == '0) ? '0 : rf_rs1_data_i;
  assign jalr_sum     = rs1_operand + jalr_imm_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_pc_d       = out_pc_q;
    out_pred_d     = out_pred_q;
    jalr_rs1_idx_d = jalr_rs1_idx_q;
    jalr_imm_d     = jalr_imm_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (flush_i) begin
          pc_d = flush_pc_i;
        end else if (ifu_req_ready_i) begin
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (flush_i) begin
          pc_d    = flush_pc_i;
          state_d = ifu_rsp_valid_i ? ST_REQ : ST_DROP;
        end else if (rsp_fire) begin
          out_valid_d = 1'b1;
          out_instr_d = ifu_rsp_instr_i;
          out_pc_d    = pc_q;
          out_pred_d  = pred_taken;
          if (dec_jalr_i) begin
            jalr_rs1_idx_d = dec_jalr_rs1_idx_i;
            jalr_imm_d     = dec_bjp_imm_i;
            state_d        = ST_JALR_WAIT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_JALR_WAIT: begin
        if (flush_i) begin
          pc_d    = flush_pc_i;
          state_d = ST_REQ;
        end else if (rs1_ready) begin
          pc_d    = {jalr_sum[XLEN-1:1], 1'b0};
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (flush_i) begin
          pc_d = flush_pc_i;
        end else if (ifu_rsp_valid_i) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (flush_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_REQ;
      pc_q           <= RESET_PC;
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= '0;
      out_pred_q     <= 1'b0;
      jalr_rs1_idx_q <= '0;
      jalr_imm_q     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_pc_q       <= out_pc_d;
      out_pred_q     <= out_pred_d;
      jalr_rs1_idx_q <= jalr_rs1_idx_d;
      jalr_imm_q     <= jalr_imm_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_instr_o      = out_instr_q;
  assign out_pc_o         = out_pc_q;
  assign out_pred_taken_o = out_pred_q;
endmodule

`default_nettype wire

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage PC generator and instruction output buffer. It consumes the fetch mini-decode results (branch/jump flags, jalr rs1 index, sign-extended immediate) for each returned instruction and computes a statically predicted next PC. It issues one instruction-memory request at a time and presents fetched instructions to the decode stage. It sits between the instruction-memory port, the fetch mini-decoder, the regfile read port for jalr, and the EXU redirect/flush path.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- ifu_req_valid_o  out  1  memory request valid
- ifu_req_ready_i  in  1  memory accepts request
- ifu_req_pc_o  out  `XLEN  request address
- ifu_rsp_valid_i  in  1  instruction returned
- ifu_rsp_ready_o  out  1  block accepts response
- ifu_rsp_instr_i  in  `INSTR_WIDTH  returned instruction; also drives the mini-decoder externally
- dec_bxx_i / dec_jal_i / dec_jalr_i  in  1 each  mini-decode flags for ifu_rsp_instr_i
- dec_jalr_rs1_idx_i  in  `REG_IDX_WIDTH  jalr base register
- dec_bjp_imm_i  in  `XLEN  sign-extended branch/jump immediate
- rf_rs1_idx_o  out  `REG_IDX_WIDTH  regfile read index (registered jalr rs1)
- rf_rs1_data_i  in  `XLEN  regfile read data, combinational
- rf_rs1_busy_i  in  1  rs1 has a pending write in the pipeline
- flush_i  in  1  EXU redirect
- flush_pc_i  in  `XLEN  redirect target
- out_valid_o  out  1  instruction valid to decode
- out_ready_i  in  1  decode accepts
- out_instr_o  out  `INSTR_WIDTH  instruction
- out_pc_o  out  `XLEN  instruction PC
- out_pred_taken_o  out  1  fetch predicted taken

## Operation
- Registers: pc_q (reset RESET_PC), state, out_valid_q/instr/pc/pred, jalr_rs1_idx_q, jalr_imm_q.
- States: REQ, RSP, JALR_WAIT, DROP. Reset state: REQ.
- REQ: ifu_req_valid_o=1, ifu_req_pc_o=pc_q. If ifu_req_ready_i=1, go to RSP. Valid and PC are held stable until accepted, except on flush.
- RSP: ifu_rsp_ready_o = ~out_valid_q | out_ready_i. On accept, write the output register with the instruction, pc_q and the prediction, then compute next PC:
  - bxx: taken iff dec_bjp_imm_i[XLEN-1]=1 (backward). Next = pc_q+imm if taken, else pc_q+4.
  - jal: next = pc_q+imm, taken.
  - jalr: taken. Capture idx/imm and go to JALR_WAIT.
  - Otherwise: next = pc_q+4.
  - Non-jalr cases: pc_q <= next, go to REQ.
- JALR_WAIT: rf_rs1_idx_o=jalr_rs1_idx_q. If idx==0, operand=0 and busy is ignored. If not busy, pc_q <= (rs1+imm) & ~1 and go to REQ; else stay.
- DROP: ifu_rsp_ready_o=1. Discard one response, then go to REQ.
- All adds wrap modulo 2^XLEN. Misaligned targets are not checked here.
- Output register: out_valid_q cleared on out_valid_o & out_ready_i unless reloaded in the same cycle.
- flush_i has priority over every other event:
  - pc_q <= flush_pc_i; out_valid_q <= 0.
  - From REQ: stay REQ with the new PC.
  - From JALR_WAIT: go to REQ.
  - From RSP: if ifu_rsp_valid_i is high the same cycle, discard it (not written to the output) and go to REQ; otherwise go to DROP.
  - From DROP: stay DROP with the new PC.
- Reset mid-operation returns to REQ with pc_q=RESET_PC. Any outstanding memory response is the memory's responsibility (memory is reset together with this block).

## Timing
- Reset values: ifu_req_valid_o=0 while rst_i=1; ifu_rsp_ready_o=0; out_valid_o=0; out_instr_o/out_pc_o/out_pred_taken_o=0; rf_rs1_idx_o=0.
- ifu_req_valid_o=1 in the first cycle after rst_i falls.
- Response accepted in cycle N: out_valid_o=1 at N+1, and the next request appears at N+1 (non-jalr).
- Best-case throughput: one instruction per 2 cycles with a zero-wait memory.
- jalr: at least one JALR_WAIT cycle. The request appears the cycle after the first not-busy cycle.
- Flush in cycle N: the request for flush_pc_i appears at N+1, or one cycle after the dropped response.

## Structure
- Shared defines in the common header: `XLEN, `INSTR_WIDTH, `REG_IDX_WIDTH, plus state encodings IFU_ST_REQ/RSP/JALR_WAIT/DROP.
- One natural sub-module: fetch_next_pc (combinational next-PC/prediction select).

## Test plan
- Reset release, ready tied high → requests at 0x8000_0000, then 0x8000_0004, then 0x8000_0008 with nop responses; out_pc_o follows.
- beq with imm -8 at 0x8000_0010 → next request 0x8000_0008, pred_taken=1. Same with imm +16 → 0x8000_0014, pred_taken=0.
- jal with imm 0x100 at 0x8000_0020 → next request 0x8000_0120, pred_taken=1.
- jalr x5 (data 0x8000_1003), imm 4, busy for 3 cycles → no request for 3 cycles, then request 0x8000_1006. jalr x0 with busy=1 → request imm&~1 immediately.
- Flush to 0x8000_4000 in RSP with no response → next response dropped (out_valid_o stays 0), then request 0x8000_4000.
- out_ready_i low 5 cycles with out_valid_o=1 → ifu_rsp_ready_o=0 and out_instr_o stable; progress resumes the cycle after out_ready_i rises.
